// File: rtl/dma_pkg.sv
// Shared types and helpers for the DMA read/write engines.
package dma_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Counter width that can hold the value depth itself, not just depth-1.
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  // True when every address bit below one beat is zero.
  function automatic logic beat_aligned(input logic [63:0] value, input int bytes);
    return (value & (64'(bytes) - 64'd1)) == 64'd0;
  endfunction

endpackage

// File: rtl/dma_sync_fifo.sv
// First-word-fall-through synchronous FIFO with occupancy count.
module dma_sync_fifo
  import dma_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = cnt_width(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head_data,
  output logic              empty,
  output logic [CNT_W-1:0]  count
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              full;
  logic              do_push;
  logic              do_pop;

  assign full      = (count == CNT_W'(DEPTH));
  assign empty     = (count == '0);
  assign do_pop    = pop && !empty;
  assign do_push   = push && (!full || do_pop);
  assign head_data = mem[rd_ptr];

  // NOTE: storage is not reset; the pointers and count alone decide which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

endmodule

// File: rtl/dma_rd_engine.sv
// DMA read engine: credit-limited request issue, in-order response buffering,
// and a valid/ready output stream with last-beat marker.
module dma_rd_engine
  import dma_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int LEN_W     = 16,
  parameter int MAX_OUTST = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [LEN_W-1:0]  len_beats,
  input  logic [ADDR_W-1:0] stride,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] mem_rd_addr,
  output logic              mem_rd_valid,
  input  logic              mem_rd_ready,
  input  logic [DATA_W-1:0] mem_rsp_data,
  input  logic              mem_rsp_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last
);

  localparam int BYTES = DATA_W / 8;
  localparam int CNT_W = cnt_width(MAX_OUTST);
  localparam int OCC_W = CNT_W + 1;

  state_t            state;
  state_t            state_nxt;
  logic [LEN_W-1:0]  issue_left;
  logic [LEN_W-1:0]  rcv_left;
  logic [LEN_W-1:0]  pop_left;
  logic [ADDR_W-1:0] stride_q;
  logic [CNT_W-1:0]  in_flight;
  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_empty;
  logic              cmd_ok;
  logic              accept_cmd;
  logic              req_fire;
  logic              rsp_accept;
  logic              pop;
  logic              last_req;
  logic              last_pop;
  logic [OCC_W-1:0]  occ_next;
  logic              req_valid_nxt;

  assign cmd_ok     = (len_beats != '0) && beat_aligned(64'(src_addr), BYTES)
                      && beat_aligned(64'(stride), BYTES);
  assign accept_cmd = (state == IDLE) && start && cmd_ok;
  assign req_fire   = mem_rd_valid && mem_rd_ready;
  assign rsp_accept = mem_rsp_valid && (in_flight != '0);
  assign pop        = out_valid && out_ready;
  assign last_req   = req_fire && (issue_left == LEN_W'(1));
  assign last_pop   = pop && (pop_left == LEN_W'(1));

  // Occupancy after this edge; a response only moves a beat from in_flight to the FIFO.
  assign occ_next = OCC_W'(in_flight) + OCC_W'(fifo_count) + OCC_W'(req_fire) - OCC_W'(pop);

  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign out_valid = !fifo_empty;
  assign out_last  = out_valid && (pop_left == LEN_W'(1));

  // NOTE: defaults are assigned first so every path drives the outputs and no latch is inferred.
  always_comb begin
    state_nxt     = state;
    req_valid_nxt = 1'b0;
    case (state)
      IDLE:  if (accept_cmd) state_nxt = ISSUE;
      ISSUE: begin
        if (last_req) begin
          state_nxt = DRAIN;
        end else if (mem_rd_valid && !mem_rd_ready) begin
          req_valid_nxt = 1'b1;
        end else begin
          req_valid_nxt = (occ_next < OCC_W'(MAX_OUTST));
        end
      end
      DRAIN: if (last_pop) state_nxt = DONE;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      mem_rd_valid <= 1'b0;
      mem_rd_addr  <= '0;
      err          <= 1'b0;
      issue_left   <= '0;
      rcv_left     <= '0;
      pop_left     <= '0;
      stride_q     <= '0;
      in_flight    <= '0;
    end else begin
      state        <= state_nxt;
      mem_rd_valid <= req_valid_nxt;
      err          <= (state == IDLE) && start && !cmd_ok;
      in_flight    <= in_flight + CNT_W'(req_fire) - CNT_W'(rsp_accept);
      if (accept_cmd) begin
        mem_rd_addr <= src_addr;
        issue_left  <= len_beats;
        rcv_left    <= len_beats;
        pop_left    <= len_beats;
        stride_q    <= stride;
      end else begin
        if (req_fire) begin
          mem_rd_addr <= mem_rd_addr + stride_q;
          issue_left  <= issue_left - LEN_W'(1);
        end
        if (rsp_accept) rcv_left <= rcv_left - LEN_W'(1);
        if (pop)        pop_left <= pop_left - LEN_W'(1);
      end
    end
  end

  dma_sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (MAX_OUTST)
  ) u_rsp_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (rsp_accept),
    .push_data (mem_rsp_data),
    .pop       (pop),
    .head_data (out_data),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  rsp_needs_request: assert property (@(posedge clk) disable iff (rst)
    mem_rsp_valid |-> (in_flight != '0 && rcv_left != '0));

endmodule

// File: doc/dma_rd_engine.md
Name: dma_rd_engine

Overview:
Parametrised DMA read engine, the next generation of the single-word read address sequencer. It issues a programmed number of beat reads over a valid/ready request channel. Up to MAX_OUTST requests may be outstanding, and the address step is configurable. In-order read responses are buffered in a credit-protected FIFO and forwarded downstream on a valid/ready stream with a last-beat marker. It sits between the DMA top-level control/aligner and the memory read port.

Parameters:
ADDR_W, 32, address width in bits
DATA_W, 32, beat width in bits; power of two, >= 8; BYTES = DATA_W/8
LEN_W, 16, width of beat-count field
MAX_OUTST, 4, maximum in-flight requests and FIFO depth; power of two, >= 2

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
start  in  1  one-cycle command strobe
src_addr  in  ADDR_W  first beat byte address
len_beats  in  LEN_W  beats to transfer
stride  in  ADDR_W  byte increment per beat; 0 = fixed address (FIFO-style peripheral)
busy  out  1  command in progress
done  out  1  one-cycle pulse after last beat accepted downstream
err  out  1  one-cycle pulse on rejected command
mem_rd_addr  out  ADDR_W  request address
mem_rd_valid  out  1  request valid
mem_rd_ready  in  1  memory accepts request
mem_rsp_data  in  DATA_W  response data, in request order
mem_rsp_valid  in  1  response valid; no backpressure on this channel
out_data  out  DATA_W  stream data
out_valid  out  1  stream valid
out_ready  in  1  downstream accepts
out_last  out  1  marks final beat

Behaviour:
- Reset values: busy=0, done=0, err=0, mem_rd_valid=0, mem_rd_addr=0, out_valid=0, out_last=0. FIFO is emptied; all counters are 0; state is IDLE.
- States are IDLE, ISSUE, DRAIN, DONE.
- IDLE + start:
  - If len_beats==0, or src_addr[log2(BYTES)-1:0]!=0, or stride is not a multiple of BYTES: pulse err for 1 cycle, stay in IDLE, issue nothing.
  - Otherwise latch addr=src_addr, issue_left=len_beats, rcv_left=len_beats, stride. Go to ISSUE next cycle and set busy=1.
- start while busy is ignored: no err, and the command is not queued.
- ISSUE:
  - Drive mem_rd_valid=1 when credits > 0. credits = MAX_OUTST - (in_flight + fifo_count).
  - On mem_rd_valid && mem_rd_ready: addr += stride (mod 2^ADDR_W, silent wrap), issue_left--, in_flight++.
  - mem_rd_addr and mem_rd_valid are registered. While mem_rd_valid=1 and mem_rd_ready=0, address and valid are held stable.
  - When the final request is accepted: go to DRAIN and drop mem_rd_valid in the same edge.
- Response handling:
  - On mem_rsp_valid, push mem_rsp_data into the FIFO, in_flight--, rcv_left--.
  - Credit accounting guarantees no overflow. A response when in_flight==0 is a protocol violation; it is ignored and flagged by an assertion.
- Output stream:
  - out_valid = FIFO non-empty; out_data = FIFO head (first-word-fall-through).
  - out_last = 1 when the head is the final beat of the command (beat counter on the pop side).
  - Pop on out_valid && out_ready.
- DRAIN -> DONE when the last beat is popped. DONE pulses done=1 for 1 cycle, clears busy, returns to IDLE. A new start is accepted the cycle after done.
- Simultaneous events:
  - Issue and response in the same cycle: in_flight unchanged.
  - Push and pop in the same cycle: fifo_count unchanged.
  - Credits use registered counts, so issue never exceeds MAX_OUTST total occupancy.
- Latency: start to first mem_rd_valid is 2 cycles. A response written at edge N is visible on out_valid after edge N (FIFO write-through is not required).
- Full throughput: 1 beat/cycle sustained when memory latency <= MAX_OUTST-1 and out_ready=1.
- Reset mid-operation: returns immediately to reset values. Responses to abandoned requests are the memory side's responsibility to flush.
- Widths:
  - issue_left, rcv_left, and the pop beat counter are LEN_W bits.
  - in_flight and fifo_count are clog2(MAX_OUTST)+1 bits.

Decomposition:
- Package dma_pkg holds:
  - the state enum (IDLE/ISSUE/DRAIN/DONE);
  - a clog2-based width helper;
  - the alignment check function shared with the write engine.
- Sub-module dma_sync_fifo: parametrised DATA_W x MAX_OUTST, first-word-fall-through, with count output. It is instantiated once for the response buffer.

Test Plan:
- src_addr=0x1000, len=4, stride=4, mem latency 1, out_ready=1 -> requests 0x1000,0x1004,0x1008,0x100C on consecutive cycles; 4 beats out in order; out_last on beat 4; single done pulse.
- len=10, stride=4, latency 6, MAX_OUTST=4 -> never more than 4 in flight; mem_rd_valid stalls on credits; all 10 beats delivered in order.
- out_ready held 0 for 20 cycles mid-transfer -> FIFO fills to 4, issue stops; no data lost; resumes on out_ready=1.
- src_addr=0xFFFFFFF8, len=3, stride=4 -> addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000; stride=0, len=3 -> three requests to the same address.
- start with len=0, then src_addr=0x1002 -> err pulses, no mem_rd_valid, busy stays 0. start while busy -> ignored.
- rst asserted during ISSUE with 2 in flight -> all outputs at reset values the same cycle; a following clean command completes normally.
